mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port round-robin arbiter that shares the single-port 4-bit nibble memory (mem_block) between two requesters, for example the push-button write path and an auto-scan/readback engine.
- Accepts one single-beat read or write per cycle and drives the memory's we/addr/din as registered outputs.
- Routes read data back to the originating requester with a fixed, pipelined latency.
- Sits between requester logic and mem_block in top.

Parameters:
- AW, 12, address width (matches mem_block addr)
- DW, 4, data width (matches mem_block din/dout)
- RD_LAT, 1, memory read latency in cycles, from mem_addr valid to mem_dout valid; legal range 0..4

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req0, req1  in  1 each  access request from requester 0/1
- we0, we1  in  1 each  1 = write, 0 = read; qualified by req
- addr0, addr1  in  AW each  access address
- wdata0, wdata1  in  DW each  write data
- gnt0, gnt1  out  1 each  command accepted this cycle (combinational)
- rvalid0, rvalid1  out  1 each  read data valid for requester 0/1
- rdata  out  DW  read data, shared by both requesters; qualified by rvalid0/rvalid1
- busy  out  1  one or more reads in flight
- mem_we  out  1  to mem_block we
- mem_addr  out  AW  to mem_block addr
- mem_din  out  DW  to mem_block din
- mem_dout  in  DW  from mem_block dout

Behaviour:
- Reset (async assert, sync release):
  - mem_we=0, mem_addr=0, mem_din=0.
  - rvalid0=rvalid1=0, busy=0.
  - gnt0=gnt1 forced 0 while reset_n=0.
  - Priority pointer last=1, so requester 0 wins the first contention.
  - All in-flight read tags are cleared. No rvalid may appear for a read issued before reset.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt high. The command transfers in the cycle where req && gnt.
  - At most one gnt per cycle; gnt0 and gnt1 are never high together.
  - A requester may keep req high across back-to-back grants.
- Arbitration:
  - Only one req high: grant it.
  - Both high: grant the requester != last. On every grant, last <= granted id.
  - No req: no gnt, last unchanged.
- Issue stage (registered), in the cycle after grant T (T+1):
  - mem_addr = granted addr.
  - mem_din = granted wdata.
  - mem_we = granted we, held for exactly one cycle.
  - With no grant in T: mem_we=0 at T+1; mem_addr/mem_din hold their previous values.
- Read return:
  - A read granted at T pushes tag {valid, id} into a (1+RD_LAT)-deep shift pipeline.
  - At T+1+RD_LAT the matching rvalid is high for one cycle and rdata = mem_dout. Latency from gnt is 2 at the default.
  - Writes generate no rvalid.
  - rdata = mem_dout whenever the tag is valid, otherwise holds its last value.
- Throughput and ordering:
  - Full pipelining: one access per cycle, any read/write mix.
  - Ordering is strictly issue order. A read granted after a write to the same address returns the new data.
- busy: high whenever any pipeline tag is valid.
- Simultaneous events: a grant and a return in the same cycle are independent and must both occur.
- Reset mid-operation:
  - Pending tags are discarded, outputs return to reset values immediately, and the pointer returns to last=1.
  - Requesters re-request after release.
- No address or range checks: addresses wrap modulo 2^AW by width truncation.

Test Plan:
- Reset, then req0 write addr=0x005 data=0x9 -> gnt0 in the same cycle, next cycle mem_we=1 mem_addr=0x005 mem_din=0x9 for one cycle only, rvalid0/rvalid1 stay 0.
- After that write, req1 read addr=0x005 -> gnt1; two cycles after gnt1, rvalid1=1 and rdata=0x9; rvalid0 stays 0; busy is high for those two cycles.
- req0 and req1 both held high for 6 cycles, all reads -> grant sequence 0,1,0,1,0,1 and six rvalid pulses in the same order with the correct per-address data.
- Back-to-back pipelining: req0 writes 0xA to 0x0FF, then reads 0x0FF in the next cycle -> read returns 0xA; mem_we pattern is 1,0.
- Wrap and edge: write 0xF to 0xFFF, then read 0xFFF and 0x000 -> 0xF and the earlier value at 0x000 are returned in order.
- Assert reset_n=0 one cycle after a read grant -> all outputs 0 immediately, no rvalid after release, and the first contention after release grants requester 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port nibble memory.
// Grants are combinational, the memory command is registered, read data returns after 1+RD_LAT cycles.
module mem_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    logic              last;
    logic [RD_LAT:0]   tag_vld;
    logic [RD_LAT:0]   tag_id;
    logic [DW-1:0]     rdata_q;
    logic              rd_push;

    // Contention goes to the requester that did not win last time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            if (req0 && (!req1 || last))
                gnt0 = 1'b1;
            else if (req1)
                gnt1 = 1'b1;
        end
    end

    assign rd_push = (gnt0 && !we0) || (gnt1 && !we1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last     <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            tag_vld  <= '0;
            tag_id   <= '0;
            rdata_q  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (gnt0) begin
                last     <= 1'b0;
                mem_we   <= we0;
                mem_addr <= addr0;
                mem_din  <= wdata0;
            end else if (gnt1) begin
                last     <= 1'b1;
                mem_we   <= we1;
                mem_addr <= addr1;
                mem_din  <= wdata1;
            end

            // Stage k of the tag pipeline lines up with the memory k cycles after issue.
            tag_vld[0] <= rd_push;
            tag_id[0]  <= gnt1;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end

            if (tag_vld[RD_LAT])
                rdata_q <= mem_dout;
        end
    end

    assign rvalid0 = tag_vld[RD_LAT] && !tag_id[RD_LAT];
    assign rvalid1 = tag_vld[RD_LAT] &&  tag_id[RD_LAT];
    assign rdata   = tag_vld[RD_LAT] ? mem_dout : rdata_q;
    assign busy    = |tag_vld;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-requester traffic,
// checked against a transaction-level model (issue-order memory image and a return queue).
module tb_mem_arbiter;
    localparam int AW     = 12;
    localparam int DW     = 4;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy, mem_we;
    logic [DW-1:0] rdata, mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Memory with a one-cycle registered read
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    // Reference model
    typedef struct packed {
        logic          id;
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    ret_t          rq[$];
    int            last_id;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    int            cyc;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        last_id  = 1;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_din  = '0;
    endtask

    // One clock cycle: drive at negedge, check grant, then check registered outputs after posedge.
    task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        output int g);
        logic [1:0]    exp_rv;
        logic          gw;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        g = -1;
        if (r0 && r1)  g = (last_id == 0) ? 1 : 0;
        else if (r0)   g = 0;
        else if (r1)   g = 1;
        chk("gnt", 32'({gnt1, gnt0}), (g == 0) ? 32'd1 : (g == 1) ? 32'd2 : 32'd0);
        exp_we = 1'b0;
        if (g >= 0) begin
            gw = (g == 1) ? w1 : w0;
            ga = (g == 1) ? a1 : a0;
            gd = (g == 1) ? d1 : d0;
            last_id  = g;
            exp_we   = gw;
            exp_addr = ga;
            exp_din  = gd;
            if (gw) ref_mem[ga] = gd;
            else    rq.push_back('{id: (g == 1), due: cyc + 1 + RD_LAT, data: ref_mem[ga]});
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("mem_we",   32'(mem_we),   32'(exp_we));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("mem_din",  32'(mem_din),  32'(exp_din));
        exp_rv = 2'b00;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_rv = rq[0].id ? 2'b10 : 2'b01;
            chk("rdata", 32'(rdata), 32'(rq[0].data));
        end
        chk("rvalid", 32'({rvalid1, rvalid0}), 32'(exp_rv));
        chk("busy", 32'(busy), 32'(rq.size() > 0));
        if (exp_rv != 2'b00) void'(rq.pop_front());
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, g);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},    32'({gnt1, gnt0}), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we),       32'd0);
        chk({tag, "_addr"},   32'(mem_addr),     32'd0);
        chk({tag, "_din"},    32'(mem_din),      32'd0);
        chk({tag, "_rvalid"}, 32'({rvalid1, rvalid0}), 32'd0);
        chk({tag, "_busy"},   32'(busy),         32'd0);
    endtask

    initial begin
        int            g;
        logic          p0, p1, pw0, pw1;
        logic [AW-1:0] pa0, pa1;
        logic [DW-1:0] pd0, pd1;
        int            n0, n1;

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        cyc = 0;
        model_reset();

        // Reset state with both requesters asking
        req0 = 1'b1; req1 = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        reset_n = 1'b1;

        // Write then read back through the other port
        step(1, 1, 12'h005, 4'h9, 0, 0, '0, '0, g);
        step(0, 0, '0, '0, 1, 0, 12'h005, '0, g);
        idle(3);

        // Sustained contention, all reads
        n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, AW'(12'h010 + n0), '0, 1, 0, AW'(12'h020 + n1), '0, g);
            if (g == 0) n0++;
            if (g == 1) n1++;
        end
        idle(3);

        // Back-to-back write/read on one port
        step(1, 1, 12'h0FF, 4'hA, 0, 0, '0, '0, g);
        step(1, 0, 12'h0FF, '0,   0, 0, '0, '0, g);
        idle(3);

        // Top-of-range write, then reads at both ends of the address space
        step(1, 1, 12'hFFF, 4'hF, 0, 0, '0, '0, g);
        step(1, 0, 12'hFFF, '0,   0, 0, '0, '0, g);
        step(0, 0, '0, '0,        1, 0, 12'h000, '0, g);
        idle(3);

        // Random traffic; a requester holds its command until granted
        p0 = 1'b0; p1 = 1'b0;
        pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!p0) begin
                p0  = ($urandom_range(0, 3) != 0);
                pw0 = 1'($urandom_range(0, 1));
                pa0 = AW'($urandom_range(0, 15));
                pd0 = DW'($urandom_range(0, 15));
            end
            if (!p1) begin
                p1  = ($urandom_range(0, 3) != 0);
                pw1 = 1'($urandom_range(0, 1));
                pa1 = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                pd1 = DW'($urandom_range(0, 15));
            end
            step(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, g);
            if (g == 0) p0 = 1'b0;
            if (g == 1) p1 = 1'b0;
        end
        idle(3);

        // Reset one cycle after a read grant: the in-flight read must vanish
        step(0, 0, '0, '0, 1, 0, 12'h005, '0, g);
        step(1, 0, 12'h00A, '0, 0, 0, '0, '0, g);
        @(negedge clk);
        reset_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        check_reset_outputs("midreset_hold");
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        reset_n = 1'b1;
        model_reset();
        idle(3);
        step(1, 0, 12'h030, '0, 1, 0, 12'h031, '0, g);
        step(0, 0, '0, '0, 1, 0, 12'h031, '0, g);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
